reg_writeback: RTL and testbench

- Write-back controller: producer side of the register-file write port (RegWrite / WriteAddr / Writedata).
- Collects results from the ALU and the load path into a small FIFO and retires one register write per cycle.
- Splits multiply/divide results into two ordered writes: Rd, then R15.
- Exports a pending-write mask so decode can stall on RAW hazards.

---
 rtl/reg_writeback_pkg.sv | 18 +
 rtl/reg_writeback_fifo.sv | 75 +++++++
 rtl/reg_writeback.sv | 161 ++++++++++++++++
 tb/tb_reg_writeback.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_writeback_pkg.sv
// wb_pkg: shared widths, register-file write entry and write-back FSM states.
package wb_pkg;

  localparam int unsigned REG_W  = 16;
  localparam int unsigned ADDR_W = 4;
  localparam logic [ADDR_W-1:0] R15_ADDR = 4'hF;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [REG_W-1:0]  data;
  } wb_entry_t;

  typedef enum logic {
    IDLE,
    HI
  } wb_state_t;

endpackage

// File: rtl/reg_writeback_fifo.sv
// wb_fifo: DEPTH-entry FIFO of pending register writes.
//   push/push_entry : enqueue (ignored when full)
//   pop/head        : dequeue / current head entry (ignored when empty)
//   full/empty/count: occupancy from registered state
//   ent_valid/ent_addr: per-slot occupancy and address, for the hazard mask
module wb_fifo
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            push,
  input  wb_entry_t                       push_entry,
  input  logic                            pop,
  output wb_entry_t                       head,
  output logic                            full,
  output logic                            empty,
  output logic [$clog2(DEPTH+1)-1:0]      count,
  output logic [DEPTH-1:0]                ent_valid,
  output logic [DEPTH-1:0][ADDR_W-1:0]    ent_addr
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  wb_entry_t          mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic               do_push;
  logic               do_pop;
  logic [PTR_W-1:0]   offset;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  // Pointers wrap naturally: DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A slot is occupied when its distance from the read pointer is below count.
  always_comb begin
    ent_valid = '0;
    ent_addr  = '0;
    offset    = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      offset       = PTR_W'(i) - rd_ptr;
      ent_valid[i] = (CNT_W'(offset) < count);
      ent_addr[i]  = mem[i].addr;
    end
  end

endmodule

// File: rtl/reg_writeback.sv
// reg_writeback: write-back controller feeding the register-file write port.
//   alu_*      : ALU result (optionally paired with an R15 write), ready on full accept
//   mem_*      : load result, priority over ALU
//   hold       : register file busy, no write this cycle
//   RegWrite/WriteAddr/Writedata : registered write port
//   pending    : per-register mask of queued or in-flight writes
module reg_writeback
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH        = 4,
  parameter bit          ZERO_DISCARD = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [3:0]  alu_rd,
  input  logic [15:0] alu_data,
  input  logic        alu_hi_valid,
  input  logic [15:0] alu_hi_data,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [3:0]  mem_rd,
  input  logic [15:0] mem_data,
  input  logic        hold,
  output logic        RegWrite,
  output logic [3:0]  WriteAddr,
  output logic [15:0] Writedata,
  output logic [15:0] pending
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  wb_state_t                     state;
  wb_state_t                     state_next;
  logic [REG_W-1:0]              hi_data;
  logic                          latch_hi;
  logic                          enq;
  wb_entry_t                     enq_entry;
  logic                          keep;
  logic                          bypass;
  logic                          push;
  logic                          pop;
  wb_entry_t                     head;
  logic                          full;
  logic                          empty;
  logic [CNT_W-1:0]              count;
  logic [DEPTH-1:0]              ent_valid;
  logic [DEPTH-1:0][ADDR_W-1:0]  ent_addr;

  wb_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (enq_entry),
    .pop        (pop),
    .head       (head),
    .full       (full),
    .empty      (empty),
    .count      (count),
    .ent_valid  (ent_valid),
    .ent_addr   (ent_addr)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (int'(count) <= int'(DEPTH));
    end
  end

  // Arbiter and pair FSM. Nothing is accepted while reset is high, so a
  // producer never sees a handshake for an entry the reset then discards.
  always_comb begin
    alu_ready  = 1'b0;
    mem_ready  = 1'b0;
    enq        = 1'b0;
    enq_entry  = '0;
    latch_hi   = 1'b0;
    state_next = state;
    if (!reset) begin
      unique case (state)
        IDLE: begin
          if (mem_valid) begin
            if (!full) begin
              enq       = 1'b1;
              enq_entry = '{addr: mem_rd, data: mem_data};
              mem_ready = 1'b1;
            end
          end else if (alu_valid && !full) begin
            enq       = 1'b1;
            enq_entry = '{addr: alu_rd, data: alu_data};
            if (alu_hi_valid) begin
              latch_hi   = 1'b1;
              state_next = HI;
            end else begin
              alu_ready = 1'b1;
            end
          end
        end
        HI: begin
          if (!full) begin
            enq        = 1'b1;
            enq_entry  = '{addr: R15_ADDR, data: hi_data};
            alu_ready  = 1'b1;
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // R0 writes complete their handshake but are never stored or issued.
  assign keep   = enq && !(ZERO_DISCARD && (enq_entry.addr == '0));
  assign pop    = !hold && !empty;
  assign bypass = !hold && empty && keep;
  assign push   = keep && !bypass;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      hi_data <= '0;
    end else begin
      state <= state_next;
      if (latch_hi) hi_data <= alu_hi_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      RegWrite  <= 1'b0;
      WriteAddr <= '0;
      Writedata <= '0;
    end else if (hold) begin
      RegWrite <= 1'b0;
    end else if (!empty) begin
      RegWrite  <= 1'b1;
      WriteAddr <= head.addr;
      Writedata <= head.data;
    end else if (keep) begin
      RegWrite  <= 1'b1;
      WriteAddr <= enq_entry.addr;
      Writedata <= enq_entry.data;
    end else begin
      RegWrite <= 1'b0;
    end
  end

  // In HI the R15 half is owed but not yet queued; it still counts as pending.
  always_comb begin
    pending = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (ent_valid[i]) pending[ent_addr[i]] = 1'b1;
    end
    if (RegWrite)      pending[WriteAddr] = 1'b1;
    if (state == HI)   pending[R15_ADDR]  = 1'b1;
  end

endmodule

// File: tb/tb_reg_writeback.sv
module tb_reg_writeback;

  localparam int unsigned DEPTH = 4;
  localparam bit          ZD    = 1'b1;

  logic        clk;
  logic        reset;
  logic        alu_valid;
  logic        alu_ready;
  logic [3:0]  alu_rd;
  logic [15:0] alu_data;
  logic        alu_hi_valid;
  logic [15:0] alu_hi_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [3:0]  mem_rd;
  logic [15:0] mem_data;
  logic        hold;
  logic        RegWrite;
  logic [3:0]  WriteAddr;
  logic [15:0] Writedata;
  logic [15:0] pending;

  int errors = 0;
  int checks = 0;

  reg_writeback #(
    .DEPTH(DEPTH),
    .ZERO_DISCARD(ZD)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .alu_valid    (alu_valid),
    .alu_ready    (alu_ready),
    .alu_rd       (alu_rd),
    .alu_data     (alu_data),
    .alu_hi_valid (alu_hi_valid),
    .alu_hi_data  (alu_hi_data),
    .mem_valid    (mem_valid),
    .mem_ready    (mem_ready),
    .mem_rd       (mem_rd),
    .mem_data     (mem_data),
    .hold         (hold),
    .RegWrite     (RegWrite),
    .WriteAddr    (WriteAddr),
    .Writedata    (Writedata),
    .pending      (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, want, $time);
    end
  endtask

  // Reference model: a queue of writes still to retire, an owed R15 write,
  // and the write port as seen by the register file.
  logic [19:0] mq [$];
  logic        m_hi_owed = 1'b0;
  logic [15:0] m_hi_val  = '0;
  logic        m_we      = 1'b0;
  logic [3:0]  m_addr    = '0;
  logic [15:0] m_data    = '0;
  logic        m_armed   = 1'b0;

  always @(negedge clk) begin
    logic        e_alu, e_mem, acc, m_full, keep;
    logic [19:0] acc_e;
    logic [15:0] e_pend;
    #2;
    e_alu = 1'b0; e_mem = 1'b0; acc = 1'b0; acc_e = '0;
    m_full = (mq.size() >= DEPTH);
    if (!reset) begin
      if (m_hi_owed) begin
        if (!m_full) begin acc = 1'b1; acc_e = {4'hF, m_hi_val}; e_alu = 1'b1; end
      end else if (mem_valid) begin
        if (!m_full) begin acc = 1'b1; acc_e = {mem_rd, mem_data}; e_mem = 1'b1; end
      end else if (alu_valid && !m_full) begin
        acc = 1'b1; acc_e = {alu_rd, alu_data}; e_alu = !alu_hi_valid;
      end
    end
    e_pend = '0;
    for (int unsigned i = 0; i < mq.size(); i++) e_pend[mq[i][19:16]] = 1'b1;
    if (m_we) e_pend[m_addr] = 1'b1;
    if (m_hi_owed) e_pend[15] = 1'b1;

    if (m_armed) begin
      chk("alu_ready", alu_ready, e_alu);
      chk("mem_ready", mem_ready, e_mem);
      chk("RegWrite", RegWrite, m_we);
      chk("WriteAddr", WriteAddr, m_addr);
      chk("Writedata", Writedata, m_data);
      chk("pending", pending, e_pend);
    end

    if (reset) begin
      mq.delete();
      m_hi_owed = 1'b0; m_we = 1'b0; m_addr = '0; m_data = '0;
      m_armed = 1'b1;
    end else begin
      if (m_hi_owed) begin
        if (!m_full) m_hi_owed = 1'b0;
      end else if (!mem_valid && alu_valid && alu_hi_valid && !m_full) begin
        m_hi_owed = 1'b1;
        m_hi_val  = alu_hi_data;
      end
      keep = acc && !(ZD && acc_e[19:16] == 4'h0);
      if (hold) begin
        m_we = 1'b0;
      end else if (mq.size() > 0) begin
        {m_addr, m_data} = mq.pop_front();
        m_we = 1'b1;
      end else if (keep) begin
        {m_addr, m_data} = acc_e;
        m_we = 1'b1;
        keep = 1'b0;
      end else begin
        m_we = 1'b0;
      end
      if (keep) mq.push_back(acc_e);
    end
  end

  task automatic idle_inputs();
    alu_valid = 1'b0; alu_hi_valid = 1'b0; mem_valid = 1'b0; hold = 1'b0;
  endtask

  initial begin
    logic alu_busy;
    logic [3:0] k;
    reset = 1'b1; alu_rd = '0; alu_data = '0; alu_hi_data = '0;
    mem_rd = '0; mem_data = '0;
    idle_inputs();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #3;
    chk("rst_RegWrite", RegWrite, 1'b0);
    chk("rst_WriteAddr", WriteAddr, 4'h0);
    chk("rst_Writedata", Writedata, 16'h0);
    chk("rst_pending", pending, 16'h0);

    // single ALU write
    @(negedge clk); alu_valid = 1'b1; alu_rd = 4'd2; alu_data = 16'h0050;
    #3; chk("t1_ready", alu_ready, 1'b1);
    @(negedge clk); alu_valid = 1'b0;
    #3; chk("t1_we", RegWrite, 1'b1); chk("t1_addr", WriteAddr, 4'd2);
    chk("t1_data", Writedata, 16'h0050); chk("t1_pend", pending, 16'h0004);
    @(negedge clk);
    #3; chk("t1_we_off", RegWrite, 1'b0); chk("t1_pend_off", pending, 16'h0);

    // paired write, load waits behind the pair
    @(negedge clk); alu_valid = 1'b1; alu_rd = 4'd3; alu_data = 16'h1234;
    alu_hi_valid = 1'b1; alu_hi_data = 16'h0001;
    #3; chk("t2_ready0", alu_ready, 1'b0);
    @(negedge clk); mem_valid = 1'b1; mem_rd = 4'd7; mem_data = 16'h0777;
    #3; chk("t2_ready1", alu_ready, 1'b1); chk("t2_memwait", mem_ready, 1'b0);
    chk("t2_addr_rd", WriteAddr, 4'd3); chk("t2_data_rd", Writedata, 16'h1234);
    chk("t2_pend", pending, 16'h8008);
    @(negedge clk); alu_valid = 1'b0; alu_hi_valid = 1'b0;
    #3; chk("t2_memready", mem_ready, 1'b1); chk("t2_we_hi", RegWrite, 1'b1);
    chk("t2_addr_hi", WriteAddr, 4'hF); chk("t2_data_hi", Writedata, 16'h0001);
    @(negedge clk); mem_valid = 1'b0;
    #3; chk("t2_addr_mem", WriteAddr, 4'd7); chk("t2_data_mem", Writedata, 16'h0777);
    @(negedge clk);
    #3; chk("t2_we_off", RegWrite, 1'b0);

    // simultaneous offers: load first
    @(negedge clk); mem_valid = 1'b1; mem_rd = 4'd5; mem_data = 16'h0040;
    alu_valid = 1'b1; alu_rd = 4'd6; alu_data = 16'h6666;
    #3; chk("t3_mem_first", mem_ready, 1'b1); chk("t3_alu_wait", alu_ready, 1'b0);
    @(negedge clk); mem_valid = 1'b0;
    #3; chk("t3_alu_next", alu_ready, 1'b1); chk("t3_addr5", WriteAddr, 4'd5);
    chk("t3_data5", Writedata, 16'h0040);
    @(negedge clk); alu_valid = 1'b0;
    #3; chk("t3_addr6", WriteAddr, 4'd6); chk("t3_data6", Writedata, 16'h6666);
    @(negedge clk);

    // R0 discard
    @(negedge clk); alu_valid = 1'b1; alu_rd = 4'd0; alu_data = 16'hFFFF;
    #3; chk("t6_ready", alu_ready, 1'b1);
    @(negedge clk); alu_valid = 1'b0;
    #3; chk("t6_no_we", RegWrite, 1'b0); chk("t6_pend", pending, 16'h0);

    // hold fills the FIFO
    k = 4'd1;
    for (int unsigned c = 0; c < 6; c++) begin
      @(negedge clk); hold = 1'b1; alu_valid = 1'b1; alu_rd = k; alu_data = {4'h0, k, 8'h00};
      #3;
      chk("t4_ready_hold", alu_ready, (c < 4) ? 1'b1 : 1'b0);
      chk("t4_no_we", RegWrite, 1'b0);
      if (alu_ready) k = k + 4'd1;
    end
    chk("t4_pend_full", pending, 16'h001E);
    @(negedge clk); hold = 1'b0;
    #3; chk("t4_full_ready", alu_ready, 1'b0);
    for (int unsigned c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) begin
        #3; chk("t4_ready_after", alu_ready, 1'b1);
      end else begin
        alu_valid = 1'b0; #3;
      end
      chk("t4_we", RegWrite, 1'b1);
      chk("t4_addr", WriteAddr, c[3:0]);
      chk("t4_data", Writedata, {4'h0, c[3:0], 8'h00});
    end
    @(negedge clk);
    #3; chk("t4_we_off", RegWrite, 1'b0);

    // reset while the R15 half is owed
    @(negedge clk); alu_valid = 1'b1; alu_rd = 4'd9; alu_data = 16'hAAAA;
    alu_hi_valid = 1'b1; alu_hi_data = 16'hBBBB;
    #3; chk("t5_ready0", alu_ready, 1'b0);
    @(negedge clk); reset = 1'b1;
    #3; chk("t5_ready_rst", alu_ready, 1'b0); chk("t5_pend_hi", pending, 16'h8200);
    @(negedge clk); reset = 1'b0; idle_inputs();
    #3; chk("t5_we", RegWrite, 1'b0); chk("t5_pend", pending, 16'h0);
    for (int unsigned c = 0; c < 3; c++) begin
      @(negedge clk); #3; chk("t5_no_r15", RegWrite, 1'b0);
    end

    // randomized traffic
    alu_busy = 1'b0;
    for (int unsigned c = 0; c < 3000; c++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 199) == 0);
      hold  = ($urandom_range(0, 3) == 0) || ((c % 200) < 12);
      mem_valid = ($urandom_range(0, 9) < 4);
      mem_rd    = 4'($urandom_range(0, 15));
      mem_data  = 16'($urandom);
      if (!alu_busy) begin
        alu_valid    = 1'($urandom_range(0, 1));
        alu_rd       = 4'($urandom_range(0, 15));
        alu_data     = 16'($urandom);
        alu_hi_valid = ($urandom_range(0, 2) == 0);
        alu_hi_data  = 16'($urandom);
      end
      #3;
      alu_busy = alu_valid && !alu_ready;
    end
    @(negedge clk); idle_inputs(); reset = 1'b0;
    repeat (8) @(negedge clk);
    #4;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
